risk_gate_param: RTL and testbench

Parametrised pre-trade risk gate, next generation of the upstream/downstream risk path. Keeps a per-client exposure and limit table. Checks each CPU order against `limit - exposure` and forwards passing orders to the exchange side with valid/ready backpressure. Applies exchange cancel/fill credits every cycle. Sits between the CPU order interface and the exchange order port.

---
 rtl/risk_gate_param.sv | 135 +++++++++++++
 tb/tb_risk_gate_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_gate_param.sv
// Pre-trade risk gate: per-client exposure/limit tables, order check and forward, exchange credits.
// Define RISK_STATS_EN to build saturating accepted/rejected order counters; otherwise both read 0.
module risk_gate_param #(
  parameter int unsigned CLIENT_BITS = 5,
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned EXP_W       = 32
) (
  input  logic                   clk,
  input  logic                   HRESETn,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic [CLIENT_BITS-1:0] cpu_client_id,
  input  logic                   cpu_new_max,
  input  logic [AMT_W-1:0]       cpu_amount,
  input  logic [EXP_W-1:0]       cpu_limit,
  input  logic                   exch_valid,
  input  logic [CLIENT_BITS-1:0] exch_client_id,
  input  logic [AMT_W-1:0]       exch_amount,
  output logic                   ord_valid,
  input  logic                   ord_ready,
  output logic [CLIENT_BITS-1:0] ord_client_id,
  output logic [AMT_W-1:0]       ord_amount,
  output logic                   rej_valid,
  output logic [CLIENT_BITS-1:0] rej_client_id,
  output logic [15:0]            stat_accepted,
  output logic [15:0]            stat_rejected
);
  localparam int unsigned NUM_CLIENTS = 2**CLIENT_BITS;

  typedef enum logic [1:0] {IDLE, CHECK, SEND, REJ} state_t;
  state_t state, next_state;

  logic [EXP_W-1:0]       exposure [NUM_CLIENTS];
  logic [EXP_W-1:0]       limit    [NUM_CLIENTS];
  logic [CLIENT_BITS-1:0] lat_id;
  logic [AMT_W-1:0]       lat_amount;
  logic [EXP_W-1:0]       lat_limit;
  logic                   lat_new_max;

  logic                   accept;
  logic [EXP_W-1:0]       credit_ext, credit_base, credit_exp, eff_exp;
  logic [EXP_W:0]         sum;
  logic                   pass;

  assign accept        = cpu_valid && cpu_ready;
  assign ord_client_id = lat_id;
  assign ord_amount    = lat_amount;

  // A credit to the client under check is folded in before the limit test, so it is never lost.
  always_comb begin
    credit_ext  = {{(EXP_W-AMT_W){1'b0}}, exch_amount};
    credit_base = exposure[exch_client_id];
    credit_exp  = (credit_base > credit_ext) ? credit_base - credit_ext : '0;
    eff_exp     = (exch_valid && exch_client_id == lat_id) ? credit_exp : exposure[lat_id];
    sum         = {1'b0, eff_exp} + {{(EXP_W+1-AMT_W){1'b0}}, lat_amount};
    pass        = !sum[EXP_W] && (sum[EXP_W-1:0] <= limit[lat_id]);
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cpu_ready     = 1'b0;
    ord_valid     = 1'b0;
    rej_valid     = 1'b0;
    rej_client_id = '0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) next_state = CHECK;
      end
      CHECK: next_state = lat_new_max ? IDLE : (pass ? SEND : REJ);
      SEND: begin
        ord_valid = 1'b1;
        if (ord_ready) next_state = IDLE;
      end
      REJ: begin
        rej_valid     = 1'b1;
        rej_client_id = lat_id;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The CHECK write follows the credit write so a passing same-client order keeps the credited sum.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        exposure[i] <= '0;
        limit[i]    <= '0;
      end
      lat_id      <= '0;
      lat_amount  <= '0;
      lat_limit   <= '0;
      lat_new_max <= 1'b0;
    end else begin
      if (accept) begin
        lat_id      <= cpu_client_id;
        lat_amount  <= cpu_amount;
        lat_limit   <= cpu_limit;
        lat_new_max <= cpu_new_max;
      end
      if (exch_valid) exposure[exch_client_id] <= credit_exp;
      if (state == CHECK) begin
        if (lat_new_max) limit[lat_id]    <= lat_limit;
        else if (pass)   exposure[lat_id] <= sum[EXP_W-1:0];
      end
    end
  end

`ifdef RISK_STATS_EN
  logic [15:0] acc_cnt, rej_cnt;

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (state == SEND && ord_ready && acc_cnt != '1) acc_cnt <= acc_cnt + 16'd1;
      if (state == REJ && rej_cnt != '1)               rej_cnt <= rej_cnt + 16'd1;
    end
  end

  assign stat_accepted = acc_cnt;
  assign stat_rejected = rej_cnt;
`else
  assign stat_accepted = '0;
  assign stat_rejected = '0;
`endif

endmodule

// File: tb/tb_risk_gate_param.sv
// Randomised self-checking bench for risk_gate_param against a table-level exposure/limit model.
module tb_risk_gate_param;
  // EXP_W narrowed to 20 so the carry boundary is reachable with a handful of 16-bit orders.
  localparam int unsigned CB = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned EW = 20;
  localparam int          NC = 8;

  logic          clk = 1'b0;
  logic          HRESETn = 1'b0;
  logic          cpu_valid, cpu_ready, cpu_new_max;
  logic [CB-1:0] cpu_client_id;
  logic [AW-1:0] cpu_amount;
  logic [EW-1:0] cpu_limit;
  logic          exch_valid;
  logic [CB-1:0] exch_client_id;
  logic [AW-1:0] exch_amount;
  logic          ord_valid, ord_ready;
  logic [CB-1:0] ord_client_id;
  logic [AW-1:0] ord_amount;
  logic          rej_valid;
  logic [CB-1:0] rej_client_id;
  logic [15:0]   stat_accepted, stat_rejected;

  longint exp_m [NC];
  longint lim_m [NC];
  longint n_acc, n_rej;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     rnd_on = 1'b0;

  always #5 clk = ~clk;

  risk_gate_param #(.CLIENT_BITS(CB), .AMT_W(AW), .EXP_W(EW)) dut (
    .clk(clk), .HRESETn(HRESETn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_client_id(cpu_client_id),
    .cpu_new_max(cpu_new_max), .cpu_amount(cpu_amount), .cpu_limit(cpu_limit),
    .exch_valid(exch_valid), .exch_client_id(exch_client_id), .exch_amount(exch_amount),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_client_id(ord_client_id),
    .ord_amount(ord_amount), .rej_valid(rej_valid), .rej_client_id(rej_client_id),
    .stat_accepted(stat_accepted), .stat_rejected(stat_rejected)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      exp_m[i] = 0;
      lim_m[i] = 0;
    end
    n_acc = 0;
    n_rej = 0;
  endtask

  // One clock with an optional credit; the model applies it at the same edge.
  task automatic step(input bit cv, input int cid, input longint camt);
    exch_valid     = cv;
    exch_client_id = CB'(cid);
    exch_amount    = AW'(camt);
    @(posedge clk); #1;
    if (cv) exp_m[cid] = (exp_m[cid] > camt) ? exp_m[cid] - camt : 0;
    exch_valid = 1'b0;
  endtask

  task automatic rand_credit(output bit cv, output int cid, output longint camt);
    cv   = rnd_on && ($urandom_range(0, 2) == 0);
    cid  = int'($urandom_range(0, NC-1));
    camt = longint'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic check_stats(input string tag);
`ifdef RISK_STATS_EN
    check_eq({tag, "_acc"}, longint'(stat_accepted), (n_acc > 65535) ? 65535 : n_acc);
    check_eq({tag, "_rej"}, longint'(stat_rejected), (n_rej > 65535) ? 65535 : n_rej);
`else
    check_eq({tag, "_acc"}, longint'(stat_accepted), 0);
    check_eq({tag, "_rej"}, longint'(stat_rejected), 0);
`endif
  endtask

  // Full request: accept edge, CHECK edge (with given credit), then the expected outcome.
  task automatic do_req(input bit nm, input int id, input longint amt, input longint lim,
                        input bit cv, input int cid, input longint camt, input int hold);
    bit     pass, rv;
    int     rid;
    longint ramt;
    check_eq("cpu_ready_idle", longint'(cpu_ready), 1);
    cpu_valid     = 1'b1;
    cpu_client_id = CB'(id);
    cpu_new_max   = nm;
    cpu_amount    = AW'(amt);
    cpu_limit     = EW'(lim);
    rand_credit(rv, rid, ramt);
    step(rv, rid, ramt);
    cpu_valid = 1'b0;
    check_eq("cpu_ready_check", longint'(cpu_ready), 0);
    check_eq("ord_valid_check", longint'(ord_valid), 0);
    check_eq("rej_valid_check", longint'(rej_valid), 0);
    step(cv, cid, camt);
    pass = 1'b0;
    if (nm) lim_m[id] = lim;
    else if (exp_m[id] + amt <= lim_m[id]) begin
      pass = 1'b1;
      exp_m[id] += amt;
    end
    if (nm) begin
      check_eq("limit_upd_ready", longint'(cpu_ready), 1);
      check_eq("limit_upd_ord", longint'(ord_valid), 0);
      check_eq("limit_upd_rej", longint'(rej_valid), 0);
    end else if (pass) begin
      ord_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        check_eq("hold_ord_valid", longint'(ord_valid), 1);
        check_eq("hold_ord_id", longint'(ord_client_id), id);
        check_eq("hold_ord_amt", longint'(ord_amount), amt);
        check_eq("hold_cpu_ready", longint'(cpu_ready), 0);
        rand_credit(rv, rid, ramt);
        step(rv, rid, ramt);
      end
      ord_ready = 1'b1;
      check_eq("ord_valid", longint'(ord_valid), 1);
      check_eq("ord_id", longint'(ord_client_id), id);
      check_eq("ord_amt", longint'(ord_amount), amt);
      check_eq("ord_no_rej", longint'(rej_valid), 0);
      rand_credit(rv, rid, ramt);
      step(rv, rid, ramt);
      ord_ready = 1'b0;
      n_acc++;
      check_eq("ord_valid_drop", longint'(ord_valid), 0);
      check_eq("ready_after_ord", longint'(cpu_ready), 1);
    end else begin
      check_eq("rej_valid", longint'(rej_valid), 1);
      check_eq("rej_id", longint'(rej_client_id), id);
      check_eq("rej_no_ord", longint'(ord_valid), 0);
      rand_credit(rv, rid, ramt);
      step(rv, rid, ramt);
      n_rej++;
      check_eq("rej_pulse_end", longint'(rej_valid), 0);
      check_eq("ready_after_rej", longint'(cpu_ready), 1);
    end
  endtask

  initial begin
    cpu_valid = 1'b0; cpu_client_id = '0; cpu_new_max = 1'b0; cpu_amount = '0; cpu_limit = '0;
    exch_valid = 1'b0; exch_client_id = '0; exch_amount = '0; ord_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) HRESETn = 1'b1;
    @(posedge clk); #1;

    check_eq("rst_cpu_ready", longint'(cpu_ready), 1);
    check_eq("rst_ord_valid", longint'(ord_valid), 0);
    check_eq("rst_ord_id", longint'(ord_client_id), 0);
    check_eq("rst_ord_amt", longint'(ord_amount), 0);
    check_eq("rst_rej_valid", longint'(rej_valid), 0);
    check_eq("rst_rej_id", longint'(rej_client_id), 0);
    check_stats("rst_stats");

    do_req(0, 3, 10, 0, 0, 0, 0, 0);            // no limit yet: reject
    do_req(1, 3, 0, 100, 0, 0, 0, 0);
    do_req(0, 3, 60, 0, 0, 0, 0, 0);
    do_req(0, 3, 40, 0, 0, 0, 0, 0);            // exactly at limit
    do_req(0, 3, 1, 0, 0, 0, 0, 0);             // one over
    do_req(0, 3, 30, 0, 1, 3, 30, 0);           // same-client credit in CHECK
    step(1, 3, 500);                             // saturates to 0
    do_req(0, 3, 100, 0, 0, 0, 0, 0);
    do_req(0, 3, 0, 0, 1, 4, 20, 0);            // zero amount at limit, other-client credit
    do_req(1, 3, 0, 150, 1, 3, 50, 0);          // credit with limit update
    do_req(0, 3, 100, 0, 0, 0, 0, 0);
    do_req(0, 3, 1, 0, 0, 0, 0, 0);
    do_req(1, 3, 0, 1000, 0, 0, 0, 0);
    do_req(0, 3, 200, 0, 0, 0, 0, 5);           // backpressure hold
    do_req(1, 3, 0, 10, 0, 0, 0, 0);            // limit below exposure
    do_req(0, 3, 0, 0, 0, 0, 0, 0);
    do_req(0, 3, 5, 0, 0, 0, 0, 0);

    do_req(1, 5, 0, 20'hFFFFF, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) do_req(0, 5, 16'hFFFF, 0, 0, 0, 0, 0);
    do_req(0, 5, 16'h20, 0, 0, 0, 0, 0);        // carry out of EXP_W: reject
    do_req(0, 5, 16'hF, 0, 0, 0, 0, 0);         // lands exactly on all-ones limit
    check_stats("directed_stats");

    do_req(1, 6, 0, 1000, 0, 0, 0, 0);
    cpu_valid = 1'b1; cpu_client_id = CB'(6); cpu_new_max = 1'b0; cpu_amount = AW'(7);
    step(0, 0, 0);
    cpu_valid = 1'b0;
    step(0, 0, 0);
    check_eq("send_before_rst", longint'(ord_valid), 1);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("rst_mid_send_ord", longint'(ord_valid), 0);
    check_eq("rst_mid_send_ready", longint'(cpu_ready), 1);
    model_reset();
    @(negedge clk) HRESETn = 1'b1;
    @(posedge clk); #1;
    check_stats("post_rst_stats");
    do_req(0, 6, 0, 0, 0, 0, 0, 0);             // zero order, zero exposure, zero limit
    do_req(0, 6, 1, 0, 0, 0, 0, 0);

    model_reset();
    HRESETn = 1'b0;
    #3;
    @(negedge clk) HRESETn = 1'b1;
    @(posedge clk); #1;
    do_req(1, 2, 0, 50, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_req(0, 2, 10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) do_req(0, 2, 100, 0, 0, 0, 0, 0);
    check_stats("stats_3_2");

    rnd_on = 1'b1;
    for (int n = 0; n < 250; n++) begin
      bit     nm, cv;
      int     id, cid;
      longint amt, lim, camt;
      nm   = ($urandom_range(0, 4) == 0);
      id   = int'($urandom_range(0, NC-1));
      amt  = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(0, 16'hFFFF));
      lim  = longint'($urandom_range(0, 20'hFFFFF));
      cv   = ($urandom_range(0, 1) == 0);
      cid  = ($urandom_range(0, 1) == 0) ? id : int'($urandom_range(0, NC-1));
      camt = longint'($urandom_range(0, 16'hFFFF));
      do_req(nm, id, amt, lim, cv, cid, camt, int'($urandom_range(0, 2)));
    end
    check_stats("final_stats");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=%0d expected=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
